// File: rtl/col_data_distributor_pkg.sv
// Shared types for the column write distributor: element width, FSM states, counter width helper.
package col_pkg;

    localparam int DATA_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter over n values never collapses below one bit, so COL=1/ROWS=1 still elaborate.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/col_data_distributor_if.sv
// Stream-in / column-FIFO-out bundle of the distributor; o_stall_cnt exists only with COL_DIST_STATS_EN.
// Slave is the distributor, master is the side that sources elements and owns the FIFO full flags.
interface col_data_distributor_if #(
    parameter int COL = 3
);
    import col_pkg::*;

    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic [COL-1:0]    i_fifo_full;
    logic [DATA_W-1:0] o_data;
    logic [COL-1:0]    o_write_enable;
    logic              o_busy;
    logic              o_done;
`ifdef COL_DIST_STATS_EN
    logic [15:0]       o_stall_cnt;
`endif

    modport slave (
        input  i_data, i_valid, i_fifo_full,
        output o_ready, o_data, o_write_enable, o_busy, o_done
`ifdef COL_DIST_STATS_EN
        , output o_stall_cnt
`endif
    );

    modport master (
        output i_data, i_valid, i_fifo_full,
        input  o_ready, o_data, o_write_enable, o_busy, o_done
`ifdef COL_DIST_STATS_EN
        , input o_stall_cnt
`endif
    );

endinterface

// File: rtl/col_data_distributor_idx_counter.sv
// Wrap counter 0..wrap_at advancing on en; wrap is a same-cycle pulse when en lands on wrap_at.
// Registered index, combinational wrap; holds whenever en is low.
module col_idx_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] wrap_at,
    output logic [W-1:0] idx,
    output logic         wrap
);

    assign wrap = en && (idx == wrap_at);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (en) begin
            idx <= wrap ? '0 : idx + W'(1);
        end
    end

endmodule

// File: rtl/col_data_distributor.sv
// Scatters one element stream round-robin into COL column FIFOs, ROWS rows per frame; 1-cycle write latency.
// Stalls upstream (o_ready low) while the target column FIFO is full; COL_DIST_STATS_EN adds a stall counter.
module col_data_distributor
    import col_pkg::*;
#(
    parameter int COL  = 3,
    parameter int ROWS = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    col_data_distributor_if.slave bus
);

    localparam int CW = cnt_w(COL);
    localparam int RW = cnt_w(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            col_wrap;
    logic            row_wrap;
    logic [CW-1:0]   col_idx;
    logic [RW-1:0]   row_idx;

    assign bus.o_ready = (state == FILL) && !bus.i_fifo_full[col_idx];
    assign accept      = bus.i_valid && bus.o_ready;
    assign bus.o_busy  = (state == FILL);
    assign bus.o_done  = (state == DONE);

    col_idx_counter #(.W(CW)) u_col_cnt (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .en      (accept),
        .wrap_at (COL_LAST),
        .idx     (col_idx),
        .wrap    (col_wrap)
    );

    // Row index advances on the column wrap, so the pair walks the frame in row-major order.
    col_idx_counter #(.W(RW)) u_row_cnt (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .en      (col_wrap),
        .wrap_at (ROW_LAST),
        .idx     (row_idx),
        .wrap    (row_wrap)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_valid) state_nxt = FILL;
            FILL:    if (row_wrap)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_data         <= '0;
            bus.o_write_enable <= '0;
        end else begin
            bus.o_write_enable <= accept ? (COL'(1) << col_idx) : '0;
            if (accept) begin
                bus.o_data <= bus.i_data;
            end
        end
    end

    frame_end_chk: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        row_wrap |-> (row_idx == ROW_LAST));

`ifdef COL_DIST_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && (state_nxt == FILL)) begin
            stall_cnt <= '0;
        end else if ((state == FILL) && bus.i_valid && bus.i_fifo_full[col_idx]
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_col_data_distributor.sv
// Scoreboarded bench for col_data_distributor: a COL=3/ROWS=2 instance and a COL=1/ROWS=4 instance.
`timescale 1ns/1ps
module tb_col_data_distributor;
    import col_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    col_data_distributor_if #(.COL(3)) a ();
    col_data_distributor_if #(.COL(1)) b ();

    col_data_distributor #(.COL(3), .ROWS(2)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a.slave));
    col_data_distributor #(.COL(1), .ROWS(4)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b.slave));

    typedef struct packed {
        logic [2:0] we;
        logic [8:0] dat;
        logic       last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   vec  = 0;
    int   miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every write strobe pops one expected element; o_done must coincide with the frame's last write.
    always @(negedge clk) begin
        exp_t e;
        if (a.o_write_enable != '0) begin
            if (qa.size() == 0) begin
                check("a_unexpected_write", 32'(a.o_write_enable), 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_write_enable", 32'(a.o_write_enable), 32'(e.we));
                check("a_data", 32'(a.o_data), 32'(e.dat));
                check("a_done_with_write", 32'(a.o_done), 32'(e.last));
                if (e.last) check("a_busy_at_done", 32'(a.o_busy), 32'd0);
            end
        end else if (a.o_done) begin
            check("a_unexpected_done", 32'(a.o_done), 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b.o_write_enable != '0) begin
            if (qb.size() == 0) begin
                check("b_unexpected_write", 32'(b.o_write_enable), 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_write_enable", 32'(b.o_write_enable), 32'(e.we));
                check("b_data", 32'(b.o_data), 32'(e.dat));
                check("b_done_with_write", 32'(b.o_done), 32'(e.last));
            end
        end else if (b.o_done) begin
            check("b_unexpected_done", 32'(b.o_done), 32'd0);
        end
    end

    // Drivers run at negedge+1 and sample o_ready at posedge-1; they return at negedge+1 after acceptance.
    task automatic send_a(input logic [8:0] d, input int col, input bit last, output int waits);
        bit acc = 1'b0;
        waits = 0;
        a.i_data  = d;
        a.i_valid = 1'b1;
        while (!acc) begin
            #3;
            acc = a.o_ready;
            if (acc) qa.push_back('{we: 3'(1 << col), dat: d, last: last});
            @(posedge clk);
            @(negedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 50) begin
                    check("a_accept_timeout", 32'd0, 32'd1);
                    acc = 1'b1;
                end
            end
        end
    endtask

    task automatic send_b(input logic [8:0] d, input bit last);
        bit acc = 1'b0;
        int waits = 0;
        b.i_data  = d;
        b.i_valid = 1'b1;
        while (!acc) begin
            #3;
            acc = b.o_ready;
            if (acc) qb.push_back('{we: 3'b001, dat: d, last: last});
            @(posedge clk);
            @(negedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 50) begin
                    check("b_accept_timeout", 32'd0, 32'd1);
                    acc = 1'b1;
                end
            end
        end
    endtask

    task automatic gap(input int n);
        a.i_valid = 1'b0;
        b.i_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_a_quiet(input string tag);
        check({tag, "_ready"}, 32'(a.o_ready), 32'd0);
        check({tag, "_we"},    32'(a.o_write_enable), 32'd0);
        check({tag, "_data"},  32'(a.o_data), 32'd0);
        check({tag, "_busy"},  32'(a.o_busy), 32'd0);
        check({tag, "_done"},  32'(a.o_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        a.i_data = '0; a.i_valid = 1'b0; a.i_fifo_full = '0;
        b.i_data = '0; b.i_valid = 1'b0; b.i_fifo_full = '0;
        repeat (3) @(negedge clk);
        check_a_quiet("reset");
        check("reset_b_busy", 32'(b.o_busy), 32'd0);
        #1;
        rst_n = 1'b1;

        // Continuous stream, one frame of 6.
        for (int i = 0; i < 6; i++) send_a(9'(i + 1), i % 3, i == 5, w);
        gap(3);
        check("s1_busy_after", 32'(a.o_busy), 32'd0);

        // Column 1 full for 5 cycles while 0x002 is presented.
        send_a(9'h001, 0, 1'b0, w);
        a.i_fifo_full = 3'b010;
        a.i_data      = 9'h002;
        a.i_valid     = 1'b1;
        repeat (5) begin
            #3;
            check("s2_stall_ready", 32'(a.o_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("s2_stall_we", 32'(a.o_write_enable), 32'd0);
            #1;
        end
        a.i_fifo_full = 3'b000;
        send_a(9'h002, 1, 1'b0, w);
        check("s2_accept_after_full_drop", 32'(w), 32'd0);
        for (int i = 2; i < 6; i++) send_a(9'(i + 1), i % 3, i == 5, w);
        gap(3);
`ifdef COL_DIST_STATS_EN
        check("s2_stall_cnt", 32'(a.o_stall_cnt), 32'd5);
`endif

        // Valid toggling every other cycle.
        for (int i = 0; i < 6; i++) begin
            send_a(9'(i + 1), i % 3, i == 5, w);
            gap(1);
        end
        gap(3);

        // Reset for one cycle after 0x004 is accepted, then a clean frame.
        for (int i = 0; i < 4; i++) send_a(9'(i + 1), i % 3, 1'b0, w);
        a.i_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check_a_quiet("midreset");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) send_a(9'(9'h010 + i), i % 3, i == 5, w);
        gap(3);

        // Full flag on column 2 while column 0 is the target must not stall.
        for (int i = 0; i < 6; i++) begin
            if (i == 3) a.i_fifo_full = 3'b100;
            send_a(9'(9'h031 + i), i % 3, i == 5, w);
            if (i == 3) begin
                check("s5_nontarget_no_stall", 32'(w), 32'd0);
                a.i_fifo_full = 3'b000;
            end
        end
        gap(3);

        // Single-column instance: four rows, every write on bit 0.
        for (int i = 0; i < 4; i++) send_b(9'(9'h0A0 + i), i == 3);
        gap(3);
        check("b_busy_after", 32'(b.o_busy), 32'd0);

        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
